// File: rtl/id_ex_hazard_unit_pkg.sv
// Shared types for the ID/EX hazard unit: FSM encoding, register-index width
// and the canned control-output patterns.
package id_ex_hazard_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam int LU_CNT_W = 3;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2,
    HZ_BAD      = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_RUN = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam hz_ctl_t CTL_BUB = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam hz_ctl_t CTL_JMP = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam hz_ctl_t CTL_MEM = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam hz_ctl_t CTL_RST = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/id_ex_hazard_unit.sv
// ID/EX writer-side hazard control: load-use bubbles, jump squash, memory freeze.
// Optional HAZARD_STALL_CNT_EN adds a saturating stall_cycles performance counter.
module id_ex_hazard_unit
  import id_ex_hazard_unit_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_jump,
  input  logic             mem_stall_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [1:0]       hz_state
`ifdef HAZARD_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam logic [LU_CNT_W-1:0] CNT_LOAD = LU_CNT_W'(LOAD_USE_CYCLES - 1);

  hz_state_e           st, st_nxt, eff;
  logic [LU_CNT_W-1:0] cnt, cnt_nxt;
  hz_ctl_t             ctl;
  logic                lu;

  assign lu = ex_mem_read & id_valid & (ex_rt != REG_ZERO) &
              ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st  <= HZ_RUN;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    ctl     = CTL_RUN;
    st_nxt  = HZ_RUN;
    cnt_nxt = cnt;
    // leaving MEM_WAIT behaves as the state it interrupted, in the same cycle
    eff     = st;
    if (st == HZ_MEM_WAIT) eff = (cnt != '0) ? HZ_LU_STALL : HZ_RUN;
    if (!rst_n) begin
      ctl = CTL_RST;
    end else if (mem_stall_req) begin
      ctl    = CTL_MEM;
      st_nxt = HZ_MEM_WAIT;
    end else if (ex_jump) begin
      ctl     = CTL_JMP;
      cnt_nxt = '0;
    end else begin
      case (eff)
        HZ_LU_STALL: begin
          ctl     = CTL_BUB;
          cnt_nxt = cnt - 1'b1;
          st_nxt  = (cnt == LU_CNT_W'(1)) ? HZ_RUN : HZ_LU_STALL;
        end
        default: begin
          if (lu) begin
            ctl = CTL_BUB;
            if (LOAD_USE_CYCLES > 1) begin
              cnt_nxt = CNT_LOAD;
              st_nxt  = HZ_LU_STALL;
            end
          end
        end
      endcase
    end
  end

  assign pc_write     = ctl.pc_write;
  assign if_id_write  = ctl.if_id_write;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_bubble = ctl.id_ex_bubble;
  assign pipe_freeze  = ctl.pipe_freeze;
  assign hz_state     = st;

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                          stall_cycles <= '0;
    else if (!pc_write && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/id_ex_hazard_unit.md
Name: id_ex_hazard_unit

Overview:
- Writer-side control for the ID/EX pipeline boundary. Decides each cycle whether IF/ID advances, holds or flushes, and whether ID/EX captures the decoded instruction or a bubble.
- Consumes ID-stage operand indices plus the ID/EX register's registered mem_read, rt and jump fields.
- Drives PC write-enable, IF/ID write/flush, the ID/EX bubble select and a global freeze for multi-cycle memory waits.
- Sits between the decode logic and the ID/EX register in the 5-stage MIPS pipeline.

Parameters:
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (legal range 1..7).
- CNT_W, 32, width of the stall performance counter (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw).
- ex_mem_read  in  1  mem_read field currently held in ID/EX.
- ex_rt  in  5  rt field currently held in ID/EX.
- ex_jump  in  1  jump field currently held in ID/EX.
- mem_stall_req  in  1  data memory not ready; whole pipeline must freeze.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_bubble  out  1  ID/EX control fields forced to 0 on the next edge.
- pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- hz_state  out  2  current FSM state, for debug.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge.
- State on reset: rst_n=0 at an edge → state=RUN, bubble counter=0.
- Outputs while rst_n=0: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_freeze=0, so the pipeline drains to NOPs.
- Output timing: all outputs are combinational from the state register and current inputs. Zero-cycle response to the registered ID/EX fields.
- Load-use hazard: lu = ex_mem_read & id_valid & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)). Register $0 never causes a hazard.
- States: RUN=0, LU_STALL=1, MEM_WAIT=2. Encoding 3 is illegal and recovers to RUN on the next edge.
- Default outputs (RUN, nothing pending): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, pipe_freeze=0.
- Priority in every state: mem_stall_req > ex_jump > lu.
- mem_stall_req=1, any state:
  - pc_write=0, if_id_write=0, pipe_freeze=1, id_ex_bubble=0.
  - Next state MEM_WAIT.
  - Bubble counter is preserved; the stall resumes afterwards.
- MEM_WAIT:
  - Outputs as above while mem_stall_req=1.
  - When mem_stall_req=0, return to the saved return state: LU_STALL if counter≠0, else RUN. Evaluate that state's outputs in the same cycle.
- ex_jump=1 (not mem-stalled):
  - pc_write=1 (PC takes the jump target), if_id_flush=1, id_ex_bubble=1.
  - Clear the bubble counter; next state RUN.
  - A pending load-use stall is cancelled because the dependent instruction is squashed.
- lu=1 in RUN:
  - pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If LOAD_USE_CYCLES=1, stay in RUN; the bubble clears ex_mem_read, so lu drops next cycle.
  - Otherwise load counter=LOAD_USE_CYCLES-1 and go to LU_STALL.
- LU_STALL:
  - pc_write=0, if_id_write=0, id_ex_bubble=1. Decrement the counter each unfrozen cycle.
  - When counter reaches 1→0, next state RUN.
- Simultaneous lu and ex_jump: the jump wins, no stall.
- Reset mid-stall: the counter is discarded and the state returns to RUN.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles [CNT_W-1:0], cleared at reset.
  - Increments on every cycle with pc_write=0 and rst_n=1.
  - Saturates at all-ones; no wrap.
- When undefined: no port and no counter logic.

Decomposition:
- Shared package: state encodings (HZ_RUN, HZ_LU_STALL, HZ_MEM_WAIT), REG_ZERO=5'd0, register-index width 5.
- No sub-module needed.
- Optional: the saturating counter as sat_counter, reusable by later performance monitors.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with lu conditions present → if_id_flush=1, id_ex_bubble=1, pc_write=0; state=RUN after release.
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, LOAD_USE_CYCLES=1 → exactly one cycle of pc_write=0/id_ex_bubble=1, then full advance. Same with ex_rt=0 → no stall.
- rt-only dependency: id_rt=9=ex_rt with id_uses_rt=0 → no stall; with id_uses_rt=1 → stall.
- Jump versus load-use in the same cycle: ex_jump=1 and lu=1 → if_id_flush=1, pc_write=1, no LU_STALL entry.
- Memory wait inside a stall: LOAD_USE_CYCLES=3, assert mem_stall_req for 4 cycles on the 2nd bubble → pipe_freeze=1 for 4 cycles, total pc_write=0 cycles=7, then RUN.
- Counter (HAZARD_STALL_CNT_EN, CNT_W=4): 20 stall cycles → stall_cycles=15 and holds.
